display_scan_ctrl: RTL
======================

# display_scan_ctrl

Scan scheduler for the irrigation controller's 4-digit multiplexed 7-segment display. It generates the digit-select code and active-low digit enables from the board clock, with a dead-time blanking interval between digits. Display data updates are synchronised to frame boundaries through a request/acknowledge handshake, and the whole display blinks while an alarm is raised. It replaces the externally clocked mod-4 counter that currently steps the digit select, and it feeds the select code to the segment multiplexer.

## Interface
Parameters:
- DIV, 12500: clock cycles per digit slot (BLANK + ON); legal range BLANK+1..65535.
- BLANK, 500: dead-time cycles at the start of each slot, all digits off; legal range 1..DIV-1.
- BLINK_FRAMES, 250: frames per blink half-period; legal range 1..1023.

Ports:
- Clk  in  1  system clock; all state is on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- En  in  1  scan enable; 0 = display dark, scheduler idle.
- Alarm  in  1  level; 1 = blink the entire display.
- Upd_req  in  1  producer holds this high until Upd_ack.
- Upd_ack  out  1  one-cycle acknowledge pulse.
- Latch  out  1  one-cycle pulse; the downstream snapshot registers load the counter/level/symbol values on it.
- Frame_tick  out  1  one-cycle pulse at each frame boundary.
- Sel  out  2  digit select for the segment multiplexer.
- Blank  out  1  1 = force all segments off.
- SEG_D1, SEG_D2, SEG_D3, SEG_D4  out  1 each  digit enables, active-low.

## Operation
- Reset values: Sel=00, SEG_D1..4=1, Blank=1, Upd_ack=0, Latch=0, Frame_tick=0. State is IDLE; slot counter, blink counter and blink phase are 0.
- States:
  - IDLE: all digits off, Blank=1, Sel=00.
  - SBLANK: all digits off, Blank=1; the slot counter runs 0..BLANK-1.
  - SON: the selected digit is on, Blank=0; the slot counter runs BLANK..DIV-1.
- IDLE→SBLANK on the first clock with En=1. SBLANK→SON when the count reaches BLANK-1. SON→SBLANK when the count reaches DIV-1, and Sel increments modulo 4 on the same edge.
- En=0 in any state: the next edge enters IDLE, Sel=00, and the counters clear.
- Digit decode while in SON:
  - Sel=00 drives SEG_D1=0.
  - Sel=01 drives SEG_D2=0.
  - Sel=10 drives SEG_D3=0.
  - Sel=11 drives SEG_D4=0.
  - The other three enables stay at 1. Exactly one enable is low at most, at all times.
- Frame boundary: the SON→SBLANK transition where Sel wraps 11→00. Frame_tick is 1 in the first SBLANK cycle of Sel=00.
- Handshake:
  - If Upd_req=1 at the edge that creates a frame boundary, Upd_ack and Latch are both 1 for that first SBLANK cycle.
  - In IDLE, a pending Upd_req is acked, with Latch, on the next edge.
  - Upd_ack is never high for two consecutive cycles. The producer drops Upd_req after the ack.
  - A request still high in the cycle after an ack is treated as a new request.
- Blink:
  - While Alarm=1, the blink counter increments at each frame boundary. When it reaches BLINK_FRAMES-1, it clears and the phase toggles.
  - Phase=1 holds Blank=1 and all enables at 1 during SON. Sel keeps scanning.
  - Alarm=0 clears the counter and the phase on the next edge.
- Simultaneous En falling with a frame boundary: IDLE wins. No Frame_tick. A pending request is acked on the following cycle from IDLE.

## Timing
- Digit slot is exactly DIV cycles; frame is 4*DIV cycles. At the defaults that is 4 kHz per digit and 1 kHz per frame.
- En 0→1: the first SBLANK cycle is the cycle after the sampling edge. SEG_D1 falls BLANK cycles later.
- All outputs are registered. No combinational path runs from inputs to outputs.
- Rst_n low clears all outputs immediately, independent of Clk. Release is synchronous to the next rising edge.

## Test plan
Test parameters: DIV=8, BLANK=2, BLINK_FRAMES=2.
- Reset: assert Rst_n=0 mid-SON with no clock edge → SEG_D1..4=1111, Sel=00, Blank=1 immediately. Acks and ticks stay 0.
- Scan with En=1:
  - Sequence repeats 2 cycles all-off, then 6 cycles D1 low, then D2, D3, D4.
  - Sel steps 00→01→10→11→00 every 8 cycles.
  - Frame_tick every 32 cycles, one cycle wide.
- Handshake: raise Upd_req at cycle 5 of a frame and hold it → Upd_ack=Latch=1 for exactly one cycle at the next Frame_tick. Drop the request after → no further acks.
- Blink: set Alarm=1 → 2 frames (64 cycles) normal, then 2 frames with SEG_D1..4=1111 and Blank=1, alternating while Sel still counts. Alarm=0 → normal on the next cycle.
- En drop: En=0 during the D3 ON phase → next cycle all enables 1, Sel=00. Upd_req raised in IDLE → acked one cycle later.
- En re-enable: En=1 again → two blank cycles, then D1.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Scan scheduler for a 4-digit multiplexed 7-segment display.
// Each digit slot is DIV cycles long: BLANK dead-time cycles with every digit
// off, followed by DIV-BLANK cycles with the selected digit on. Four slots
// make one frame. Display data updates are handed over at frame boundaries
// through a request/acknowledge handshake. While Alarm is high the whole
// display blinks, with a half-period of BLINK_FRAMES frames.
//
// Ports:
//   Clk            system clock, rising edge
//   Rst_n          asynchronous active-low reset
//   En             scan enable (0 = display dark, scheduler idle)
//   Alarm          level, 1 = blink the entire display
//   Upd_req        update request, held by the producer until Upd_ack
//   Upd_ack        one-cycle acknowledge pulse
//   Latch          one-cycle snapshot-load pulse (coincides with Upd_ack)
//   Frame_tick     one-cycle pulse in the first cycle of each frame
//   Sel[1:0]       digit select for the segment multiplexer
//   Blank          1 = force all segments off
//   SEG_D1..SEG_D4 digit enables, active-low
//
// All outputs come straight from flip-flops; the next values are derived
// from the next-state values so that each output describes the cycle it is
// registered into.

module display_scan_ctrl #(
    parameter int DIV          = 12500,
    parameter int BLANK        = 500,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       En,
    input  logic       Alarm,
    input  logic       Upd_req,
    output logic       Upd_ack,
    output logic       Latch,
    output logic       Frame_tick,
    output logic [1:0] Sel,
    output logic       Blank,
    output logic       SEG_D1,
    output logic       SEG_D2,
    output logic       SEG_D3,
    output logic       SEG_D4
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SBLANK = 2'd1,
        ST_SON    = 2'd2
    } state_t;

    localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
    localparam logic [9:0]  BLINK_LAST = 10'(BLINK_FRAMES - 1);

    // Active-low enable pattern {D4,D3,D2,D1} for a select code.
    function automatic logic [3:0] digit_enables_n(input logic [1:0] sel);
        logic [3:0] pat;
        case (sel)
            2'd0:    pat = 4'b1110;
            2'd1:    pat = 4'b1101;
            2'd2:    pat = 4'b1011;
            2'd3:    pat = 4'b0111;
            default: pat = 4'b1111;
        endcase
        return pat;
    endfunction

    // Scheduler state
    state_t      state_r;
    logic [15:0] cnt_r;
    logic [1:0]  sel_r;
    logic [9:0]  blink_cnt_r;
    logic        phase_r;

    // Registered outputs
    logic        upd_ack_r;
    logic        latch_r;
    logic        frame_tick_r;
    logic        blank_r;
    logic [3:0]  seg_n_r;

    // Next-state values
    state_t      state_s;
    logic [15:0] cnt_s;
    logic [1:0]  sel_s;
    logic [9:0]  blink_cnt_s;
    logic        phase_s;
    logic        frame_bnd_s;

    // Next output values
    logic        digit_on_s;
    logic        upd_ack_s;
    logic        latch_s;
    logic        frame_tick_s;
    logic        blank_s;
    logic [3:0]  seg_n_s;

    // State register: scheduler state, slot counter, select and blink state.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 16'd0;
            sel_r       <= 2'd0;
            blink_cnt_r <= 10'd0;
            phase_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            sel_r       <= sel_s;
            blink_cnt_r <= blink_cnt_s;
            phase_r     <= phase_s;
        end
    end

    // Next-state logic: slot timing, digit stepping, frame boundary and blink.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        sel_s       = sel_r;
        frame_bnd_s = 1'b0;

        if (!En) begin
            // Disabling always wins, even over a coincident frame boundary.
            state_s = ST_IDLE;
            cnt_s   = 16'd0;
            sel_s   = 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_SBLANK;
                    cnt_s   = 16'd0;
                    sel_s   = 2'd0;
                end
                ST_SBLANK: begin
                    cnt_s = cnt_r + 16'd1;
                    if (cnt_r == BLANK_LAST) begin
                        state_s = ST_SON;
                    end else begin
                        state_s = ST_SBLANK;
                    end
                end
                ST_SON: begin
                    if (cnt_r == DIV_LAST) begin
                        state_s     = ST_SBLANK;
                        cnt_s       = 16'd0;
                        sel_s       = sel_r + 2'd1;
                        frame_bnd_s = (sel_r == 2'd3);
                    end else begin
                        state_s = ST_SON;
                        cnt_s   = cnt_r + 16'd1;
                    end
                end
                default: begin
                    // Unused encoding: fall back to a dark, idle display.
                    state_s = ST_IDLE;
                    cnt_s   = 16'd0;
                    sel_s   = 2'd0;
                end
            endcase
        end

        // Blink half-period counts frame boundaries seen while Alarm is held.
        // Leaving the scan also restarts the blink cycle from its visible half.
        if (!Alarm || !En) begin
            blink_cnt_s = 10'd0;
            phase_s     = 1'b0;
        end else if (frame_bnd_s) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_s = 10'd0;
                phase_s     = ~phase_r;
            end else begin
                blink_cnt_s = blink_cnt_r + 10'd1;
                phase_s     = phase_r;
            end
        end else begin
            blink_cnt_s = blink_cnt_r;
            phase_s     = phase_r;
        end
    end

    // Output decode: next output values from the next state and inputs.
    always_comb begin
        digit_on_s = (state_s == ST_SON) && !phase_s;

        if (digit_on_s) begin
            seg_n_s = digit_enables_n(sel_s);
        end else begin
            seg_n_s = 4'b1111;
        end
        blank_s = ~digit_on_s;

        frame_tick_s = frame_bnd_s;

        // Gating on the previous ack keeps the pulse one cycle wide; a request
        // still high one cycle later is then served as a fresh request.
        upd_ack_s = Upd_req && !upd_ack_r && (frame_bnd_s || (state_r == ST_IDLE));
        latch_s   = upd_ack_s;
    end

    // Output register: every port is driven from a flip-flop.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            upd_ack_r    <= 1'b0;
            latch_r      <= 1'b0;
            frame_tick_r <= 1'b0;
            blank_r      <= 1'b1;
            seg_n_r      <= 4'b1111;
        end else begin
            upd_ack_r    <= upd_ack_s;
            latch_r      <= latch_s;
            frame_tick_r <= frame_tick_s;
            blank_r      <= blank_s;
            seg_n_r      <= seg_n_s;
        end
    end

    assign Upd_ack    = upd_ack_r;
    assign Latch      = latch_r;
    assign Frame_tick = frame_tick_r;
    assign Sel        = sel_r;
    assign Blank      = blank_r;
    assign SEG_D1     = seg_n_r[0];
    assign SEG_D2     = seg_n_r[1];
    assign SEG_D3     = seg_n_r[2];
    assign SEG_D4     = seg_n_r[3];

endmodule
